// File: rtl/dhrut_pkg.sv
// Shared types and constants for the RV32I decode stage: opclass encoding,
// major opcodes, fetch-packet field offsets and the registered ID packet layout.
package dhrut_pkg;

   localparam int PC_MSB    = 63;
   localparam int PC_LSB    = 32;
   localparam int INSTR_MSB = 31;
   localparam int INSTR_LSB = 0;

   localparam int OPCLASS_W = 4;
   localparam int REG_W     = 5;
   localparam int FUNCT3_W  = 3;
   localparam int IMM_W     = 32;
   localparam int XLEN      = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [OPCLASS_W-1:0] {
      OC_LUI     = 4'd0,
      OC_AUIPC   = 4'd1,
      OC_JAL     = 4'd2,
      OC_JALR    = 4'd3,
      OC_BRANCH  = 4'd4,
      OC_LOAD    = 4'd5,
      OC_STORE   = 4'd6,
      OC_OPIMM   = 4'd7,
      OC_OP      = 4'd8,
      OC_FENCE   = 4'd9,
      OC_SYSTEM  = 4'd10,
      OC_ILLEGAL = 4'd11
   } opclass_t;

   typedef struct packed {
      logic [XLEN-1:0]     pc;
      logic [XLEN-1:0]     instr;
      opclass_t            opclass;
      logic [REG_W-1:0]    rs1;
      logic [REG_W-1:0]    rs2;
      logic [REG_W-1:0]    rd;
      logic [FUNCT3_W-1:0] funct3;
      logic                funct7b5;
      logic [IMM_W-1:0]    imm;
      logic                illegal;
   } id_pkt_t;

   function automatic opclass_t opclass_of(input logic [6:0] opc);
      opclass_t oc;
      case (opc)
         OPC_LUI:    oc = OC_LUI;
         OPC_AUIPC:  oc = OC_AUIPC;
         OPC_JAL:    oc = OC_JAL;
         OPC_JALR:   oc = OC_JALR;
         OPC_BRANCH: oc = OC_BRANCH;
         OPC_LOAD:   oc = OC_LOAD;
         OPC_STORE:  oc = OC_STORE;
         OPC_OPIMM:  oc = OC_OPIMM;
         OPC_OP:     oc = OC_OP;
         OPC_FENCE:  oc = OC_FENCE;
         OPC_SYSTEM: oc = OC_SYSTEM;
         default:    oc = OC_ILLEGAL;
      endcase
      return oc;
   endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Purely combinational RV32I field decoder: opclass, register indices,
// sign-extended immediate and the illegal-encoding flag.
module rv32i_decoder
   import dhrut_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic [3:0]  o_opclass,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [4:0]  o_rd,
   output logic [2:0]  o_funct3,
   output logic        o_funct7b5,
   output logic [31:0] o_imm,
   output logic        o_illegal
);

   opclass_t    oc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   always_comb begin
      f3 = i_instr[14:12];
      f7 = i_instr[31:25];
      oc = opclass_of(i_instr[6:0]);

      imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
      imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
               i_instr[11:8], 1'b0};
      imm_u = {i_instr[31:12], 12'h000};
      imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
               i_instr[30:21], 1'b0};

      case (oc)
         OC_LUI, OC_AUIPC:                          o_imm = imm_u;
         OC_JAL:                                    o_imm = imm_j;
         OC_JALR, OC_LOAD, OC_OPIMM, OC_FENCE,
         OC_SYSTEM:                                 o_imm = imm_i;
         OC_BRANCH:                                 o_imm = imm_b;
         OC_STORE:                                  o_imm = imm_s;
         default:                                   o_imm = '0;
      endcase

      o_rs1 = (oc inside {OC_LUI, OC_AUIPC, OC_JAL}) ? 5'd0 : i_instr[19:15];
      o_rs2 = (oc inside {OC_BRANCH, OC_STORE, OC_OP}) ? i_instr[24:20] : 5'd0;
      o_rd  = (oc inside {OC_BRANCH, OC_STORE, OC_FENCE}) ? 5'd0 : i_instr[11:7];

      o_funct3   = f3;
      o_funct7b5 = i_instr[30];
      o_opclass  = oc;

      // funct7=0x20 is only meaningful for SUB (f3=0) and SRA (f3=5)
      o_illegal = (i_instr[1:0] != 2'b11) || (oc == OC_ILLEGAL)
               || ((oc == OC_JALR)   && (f3 != 3'd0))
               || ((oc == OC_BRANCH) && (f3 inside {3'd2, 3'd3}))
               || ((oc == OC_LOAD)   && (f3 inside {3'd3, 3'd6, 3'd7}))
               || ((oc == OC_STORE)  && (f3 > 3'd2))
               || ((oc == OC_OP)     && (f7 != 7'h00)
                   && !((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5)));
   end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: one registered ID packet slot plus a single-entry
// skid buffer so the packet in flight when Execute stalls is never dropped.
module decode_stage
   import dhrut_pkg::*;
#(
   parameter int IF_PKT_WIDTH = 64,
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_if_pkt_valid,
   input  logic [IF_PKT_WIDTH-1:0] i_if_pkt_data,
   output logic                    o_stall,
   input  logic                    i_flush,
   input  logic                    i_ex_stall,
   output logic                    o_id_valid,
   output logic [ADDR_WIDTH-1:0]   o_id_pc,
   output logic [DATA_WIDTH-1:0]   o_id_instr,
   output logic [3:0]              o_id_opclass,
   output logic [4:0]              o_id_rs1,
   output logic [4:0]              o_id_rs2,
   output logic [4:0]              o_id_rd,
   output logic [2:0]              o_id_funct3,
   output logic                    o_id_funct7b5,
   output logic [DATA_WIDTH-1:0]   o_id_imm,
   output logic                    o_id_illegal
);

   logic                    id_valid_q, id_valid_d;
   id_pkt_t                 id_pkt_q, id_pkt_d;
   logic                    skid_vld_q, skid_vld_d;
   logic [IF_PKT_WIDTH-1:0] skid_data_q, skid_data_d;

   logic [IF_PKT_WIDTH-1:0] sel_data;
   logic                    accept, load;
   logic [3:0]              dec_opclass;
   logic [4:0]              dec_rs1, dec_rs2, dec_rd;
   logic [2:0]              dec_funct3;
   logic                    dec_funct7b5, dec_illegal;
   logic [31:0]             dec_imm;

   // A full skid always has priority: it is older than anything Fetch offers
   assign sel_data = skid_vld_q ? skid_data_q : i_if_pkt_data;
   assign accept   = i_if_pkt_valid && !skid_vld_q;
   assign load     = !id_valid_q || !i_ex_stall;

   rv32i_decoder u_dec (
      .i_instr    (sel_data[INSTR_MSB:INSTR_LSB]),
      .o_opclass  (dec_opclass),
      .o_rs1      (dec_rs1),
      .o_rs2      (dec_rs2),
      .o_rd       (dec_rd),
      .o_funct3   (dec_funct3),
      .o_funct7b5 (dec_funct7b5),
      .o_imm      (dec_imm),
      .o_illegal  (dec_illegal)
   );

   always_comb begin
      id_valid_d  = id_valid_q;
      id_pkt_d    = id_pkt_q;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;

      if (i_flush) begin
         id_valid_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (load) begin
         id_valid_d = skid_vld_q || accept;
         skid_vld_d = 1'b0;
         if (skid_vld_q || accept) begin
            id_pkt_d.pc       = sel_data[PC_MSB:PC_LSB];
            id_pkt_d.instr    = sel_data[INSTR_MSB:INSTR_LSB];
            id_pkt_d.opclass  = opclass_t'(dec_opclass);
            id_pkt_d.rs1      = dec_rs1;
            id_pkt_d.rs2      = dec_rs2;
            id_pkt_d.rd       = dec_rd;
            id_pkt_d.funct3   = dec_funct3;
            id_pkt_d.funct7b5 = dec_funct7b5;
            id_pkt_d.imm      = dec_imm;
            id_pkt_d.illegal  = dec_illegal;
         end
      end else if (accept) begin
         // Output held by Execute: park the packet; o_stall rises next cycle
         skid_vld_d  = 1'b1;
         skid_data_d = i_if_pkt_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid_q  <= 1'b0;
         id_pkt_q    <= '0;
         skid_vld_q  <= 1'b0;
         skid_data_q <= '0;
      end else begin
         id_valid_q  <= id_valid_d;
         id_pkt_q    <= id_pkt_d;
         skid_vld_q  <= skid_vld_d;
         skid_data_q <= skid_data_d;
      end
   end

   assign o_stall       = skid_vld_q;
   assign o_id_valid    = id_valid_q;
   assign o_id_pc       = id_pkt_q.pc;
   assign o_id_instr    = id_pkt_q.instr;
   assign o_id_opclass  = id_pkt_q.opclass;
   assign o_id_rs1      = id_pkt_q.rs1;
   assign o_id_rs2      = id_pkt_q.rs2;
   assign o_id_rd       = id_pkt_q.rd;
   assign o_id_funct3   = id_pkt_q.funct3;
   assign o_id_funct7b5 = id_pkt_q.funct7b5;
   assign o_id_imm      = id_pkt_q.imm;
   assign o_id_illegal  = id_pkt_q.illegal;

endmodule
